rv_mem_stage: RTL
=================

Name: rv_mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage, consuming its ALU result, memory controls, rd, pc+4, result-source select, funct3 and rs2 value.
- Registers those values, performs loads/stores on a req/ack data bus, aligns store lanes and extends load data.
- Selects the writeback result, presents it to the writeback stage and forwarding logic, and stalls the pipeline while a bus access is outstanding.

Parameters:
DBUS_TIMEOUT, 255, maximum cycles to wait for i_dbus_ack before aborting; 0 disables the watchdog.

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_flush  in  1  synchronous flush of the stage register (bubble insert)
i_alu_result  in  32  ALU result / effective address
i_reg_write  in  1  instruction writes rd
i_mem_read  in  1  load
i_mem_write  in  1  store
i_rd  in  5  destination register
i_pc_p4  in  30  pc+4, bits [31:2]
i_res_src  in  2  result select: 0 ALU, 1 load data, 2 pc+4, 3 ALU
i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_rs2_val  in  32  store data
o_dbus_req  out  1  bus request, held until ack
o_dbus_we  out  1  1 = write
o_dbus_addr  out  30  word address [31:2]
o_dbus_be  out  4  byte enables
o_dbus_wdata  out  32  lane-aligned store data
i_dbus_ack  in  1  access complete; rdata valid for reads
i_dbus_rdata  in  32  read word
o_stall  out  1  hold all upstream stages
o_result  out  32  writeback / forwarding value
o_reg_write  out  1  qualified register write
o_rd  out  5  destination register
o_misaligned  out  1  one-cycle pulse: misaligned access dropped
o_bus_err  out  1  one-cycle pulse: bus timeout

Behaviour:
- Reset:
  - All stage registers are 0 and the FSM is in IDLE.
  - Timeout counter is 0.
  - All outputs are 0, including o_dbus_req, o_stall, o_reg_write, o_misaligned and o_bus_err.
- Stage register load:
  - At each rising edge with o_stall=0, the stage register loads the i_* values, or all zeros when i_flush=1.
  - With o_stall=1 the register holds and i_flush is ignored, so an in-flight access always completes.
- Misalignment check, made at capture:
  - Halfword access (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no bus request.
  - o_misaligned=1 for the one cycle the instruction sits in the stage; o_reg_write is 0 for it.
- FSM IDLE:
  - If the captured instruction is an aligned load or store, go to BUS on the capture edge; otherwise stay in IDLE.
- FSM BUS:
  - o_dbus_req=1. addr, we, be and wdata are driven from the stage register and stay stable until ack.
  - o_stall = BUS & !i_dbus_ack (combinational).
  - On ack: return to IDLE; a load uses i_dbus_rdata combinationally that same cycle.
  - Ack in the first BUS cycle gives zero stall cycles.
- Watchdog:
  - The counter increments each BUS cycle without ack.
  - When it reaches DBUS_TIMEOUT (if nonzero): o_bus_err pulses, the FSM returns to IDLE, o_stall drops, o_reg_write=0 for that instruction, and the counter clears.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = rs2[7:0] replicated ×4.
  - SH: be = 0011 << addr[1:0]; wdata = rs2[15:0] replicated ×2.
  - SW: be = 1111; wdata = rs2.
- Loads:
  - Select the byte or halfword at addr[1:0] (halfword at addr[1]).
  - Sign-extend for funct3 000/001; zero-extend for 100/101.
  - Word loads pass through unchanged.
- Result:
  - o_result follows res_src: ALU result, extended load data, or {pc_p4, 2'b00}.
  - o_reg_write = r_reg_write & !o_stall & !misaligned & !timeout.
  - o_rd = r_rd.
- Reset mid-access: req drops immediately (asynchronous) and the access is abandoned.

Test Plan:
- ALU op, res_src=0, alu_result=0x1234, rd=5, reg_write=1 -> next cycle o_result=0x1234, o_rd=5, o_reg_write=1, o_stall=0, no req.
- LB at addr 0x103, ack after 2 cycles, rdata=0x80FF_0000 -> req held 3 cycles, addr=0x40, be=1000, o_stall=1 for 2 cycles, then o_result=0xFFFF_FF80 with o_reg_write=1 on the ack cycle.
- SH at addr 0x202, rs2=0xAAAA_BEEF, ack in the first cycle -> we=1, be=1100, wdata=0xBEEF_BEEF, zero stall cycles.
- LW at addr 0x101 -> no req, o_misaligned=1 for 1 cycle, o_reg_write=0.
- DBUS_TIMEOUT=4, load with no ack -> o_stall high 4 cycles, then o_bus_err pulse, o_stall=0, req=0, o_reg_write=0.
- i_flush asserted during a stalled LW -> the access completes with the correct result; the flush takes effect only at the next unstalled edge, capturing zeros.

Source files
------------

// File: rtl/rv_mem_stage.sv
// rtl/rv_mem_stage.sv - RISC-V memory stage: stage register, req/ack data bus access, load/store lane handling
module rv_mem_stage #(
    parameter int DBUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_alu_result,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [4:0]  i_rd,
    input  logic [29:0] i_pc_p4,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs2_val,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [29:0] o_dbus_addr,
    output logic [3:0]  o_dbus_be,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_stall,
    output logic [31:0] o_result,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic        o_misaligned,
    output logic        o_bus_err
);
    localparam int CW = (DBUS_TIMEOUT > 1) ? $clog2(DBUS_TIMEOUT + 1) : 1;

    typedef enum logic {S_IDLE, S_BUS} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   r_alu;
    logic          r_reg_write;
    logic          r_mem_write;
    logic [4:0]    r_rd;
    logic [29:0]   r_pc_p4;
    logic [1:0]    r_res_src;
    logic [2:0]    r_funct3;
    logic [31:0]   r_rs2;
    logic          r_mis;

    logic          busy, timeout, in_mis, in_mem;
    logic [3:0]    be_calc;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Misalignment is judged on the incoming instruction so a bad access never reaches BUS
    always_comb begin
        in_mem = i_mem_read | i_mem_write;
        in_mis = in_mem & (((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                           (i_funct3[1] & (i_alu_result[1:0] != 2'b00)));
    end

    always_comb begin
        busy       = (state == S_BUS);
        timeout    = (DBUS_TIMEOUT != 0) && busy && (cnt == CW'(DBUS_TIMEOUT));
        o_dbus_req = busy & ~timeout;
        o_stall    = busy & ~i_dbus_ack & ~timeout;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (o_stall) begin
            cnt_nxt = cnt + 1'b1;
        end else if (!i_flush && in_mem && !in_mis) begin
            state_nxt = S_BUS;
        end else begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alu       <= '0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_rd        <= '0;
            r_pc_p4     <= '0;
            r_res_src   <= '0;
            r_funct3    <= '0;
            r_rs2       <= '0;
            r_mis       <= 1'b0;
        end else if (!o_stall) begin
            if (i_flush) begin
                r_alu       <= '0;
                r_reg_write <= 1'b0;
                r_mem_write <= 1'b0;
                r_rd        <= '0;
                r_pc_p4     <= '0;
                r_res_src   <= '0;
                r_funct3    <= '0;
                r_rs2       <= '0;
                r_mis       <= 1'b0;
            end else begin
                r_alu       <= i_alu_result;
                r_reg_write <= i_reg_write;
                r_mem_write <= i_mem_write;
                r_rd        <= i_rd;
                r_pc_p4     <= i_pc_p4;
                r_res_src   <= i_res_src;
                r_funct3    <= i_funct3;
                r_rs2       <= i_rs2_val;
                r_mis       <= in_mis;
            end
        end
    end

    always_comb begin
        be_calc      = 4'b1111;
        o_dbus_wdata = r_rs2;
        case (r_funct3[1:0])
            2'b00: begin
                be_calc      = 4'b0001 << r_alu[1:0];
                o_dbus_wdata = {4{r_rs2[7:0]}};
            end
            2'b01: begin
                be_calc      = 4'b0011 << r_alu[1:0];
                o_dbus_wdata = {2{r_rs2[15:0]}};
            end
            default: ;
        endcase
        o_dbus_addr = r_alu[31:2];
        o_dbus_be   = o_dbus_req ? be_calc : 4'b0000;
        o_dbus_we   = o_dbus_req & r_mem_write;
    end

    always_comb begin
        ld_byte = i_dbus_rdata[7:0];
        case (r_alu[1:0])
            2'b01:   ld_byte = i_dbus_rdata[15:8];
            2'b10:   ld_byte = i_dbus_rdata[23:16];
            2'b11:   ld_byte = i_dbus_rdata[31:24];
            default: ;
        endcase
        ld_half = r_alu[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        case (r_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = i_dbus_rdata;
        endcase
    end

    always_comb begin
        case (r_res_src)
            2'd1:    o_result = ld_data;
            2'd2:    o_result = {r_pc_p4, 2'b00};
            default: o_result = r_alu;
        endcase
        o_reg_write  = r_reg_write & ~o_stall & ~r_mis & ~timeout;
        o_rd         = r_rd;
        o_misaligned = r_mis;
        o_bus_err    = timeout;
    end
endmodule
